// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 user command port.
// Read responses are routed back to the issuing port through an in-order tag FIFO.
module ddr3_port_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 8,
    parameter int PENDING    = 4
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic                         a_cmd_valid,
    output logic                         a_cmd_ready,
    input  logic                         a_cmd_write,
    input  logic [ADDR_WIDTH-1:0]        a_cmd_addr,
    input  logic [DATA_WIDTH-1:0]        a_cmd_data,
    output logic                         a_rsp_valid,

    input  logic                         b_cmd_valid,
    output logic                         b_cmd_ready,
    input  logic                         b_cmd_write,
    input  logic [ADDR_WIDTH-1:0]        b_cmd_addr,
    input  logic [DATA_WIDTH-1:0]        b_cmd_data,
    output logic                         b_rsp_valid,

    output logic [DATA_WIDTH-1:0]        rsp_data,

    output logic                         mem_cmd_valid,
    input  logic                         mem_cmd_ready,
    output logic                         mem_cmd_write,
    output logic [ADDR_WIDTH-1:0]        mem_cmd_addr,
    output logic [DATA_WIDTH-1:0]        mem_cmd_data,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rsp_data,

    output logic [1:0]                   grant_o,
    output logic [$clog2(PENDING):0]     pending_o,
    output logic                         rsp_err_o
);

    localparam int PTR_W  = (PENDING > 1) ? $clog2(PENDING) : 1;
    localparam int CNT_W  = $clog2(PENDING) + 1;
    localparam int HOLD_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t             state;
    logic               last_b;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               tag_mem [2**PTR_W];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   pending;
    logic               rsp_err;

    logic               sel_valid;
    logic               sel_write;
    logic               other_valid;
    logic               tag_full;
    logic               tag_empty;
    logic               cmd_hs;
    logic               push;
    logic               pop;
    logic               head_b;
    logic               release_gnt;

    // Command mux: the granted port drives the controller directly
    always_comb begin
        sel_valid     = 1'b0;
        sel_write     = 1'b0;
        other_valid   = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_data  = '0;
        case (state)
            GNT_A: begin
                sel_valid    = a_cmd_valid;
                sel_write    = a_cmd_write;
                other_valid  = b_cmd_valid;
                mem_cmd_addr = a_cmd_addr;
                mem_cmd_data = a_cmd_data;
            end
            GNT_B: begin
                sel_valid    = b_cmd_valid;
                sel_write    = b_cmd_write;
                other_valid  = a_cmd_valid;
                mem_cmd_addr = b_cmd_addr;
                mem_cmd_data = b_cmd_data;
            end
            default: ;
        endcase
    end

    assign mem_cmd_write = sel_write;
    assign tag_full      = (pending == CNT_W'(PENDING));
    assign tag_empty     = (pending == '0);
    // A read needs a free tag slot; writes never wait on the tag FIFO
    assign mem_cmd_valid = sel_valid & ~(~sel_write & tag_full);
    assign cmd_hs        = mem_cmd_valid & mem_cmd_ready;
    assign a_cmd_ready   = cmd_hs & (state == GNT_A);
    assign b_cmd_ready   = cmd_hs & (state == GNT_B);
    assign release_gnt   = (cmd_hs && (hold_cnt == HOLD_W'(BURST_MAX - 1))) || !sel_valid;

    assign push          = cmd_hs & ~sel_write;
    assign pop           = mem_rsp_valid & ~tag_empty;
    assign head_b        = tag_mem[rd_ptr];
    assign a_rsp_valid   = pop & ~head_b;
    assign b_rsp_valid   = pop & head_b;
    assign rsp_data      = mem_rsp_data;

    assign grant_o       = {state == GNT_B, state == GNT_A};
    assign pending_o     = pending;
    assign rsp_err_o     = rsp_err;

    // Grant FSM: last_b set means A wins the next tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_cmd_valid && b_cmd_valid)
                        state <= last_b ? GNT_A : GNT_B;
                    else if (a_cmd_valid)
                        state <= GNT_A;
                    else if (b_cmd_valid)
                        state <= GNT_B;
                end
                GNT_A, GNT_B: begin
                    if (release_gnt) begin
                        hold_cnt <= '0;
                        last_b   <= (state == GNT_B);
                        if (other_valid)
                            state <= (state == GNT_A) ? GNT_B : GNT_A;
                        else
                            state <= IDLE;
                    end else if (cmd_hs) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag storage holds the issuing port id; contents need no reset
    always_ff @(posedge clock) begin
        if (push)
            tag_mem[wr_ptr] <= (state == GNT_B);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: ;
            endcase
            if (mem_rsp_valid && tag_empty)
                rsp_err <= 1'b1;
        end
    end

endmodule
